// File: rtl/sopc_pio_pkg.sv
// Shared definitions for the SOPC bidirectional PIO slave: register map,
// edge-type encodings and the readdata zero-extension helper.
package sopc_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Clears every bit at or above position w so unused bus lanes read 0.
  function automatic logic [31:0] pio_zext(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return v & m;
  endfunction

endpackage

// File: rtl/sopc_pio_bidir_if.sv
// Avalon-MM slave bus bundle for the PIO port (zero wait states, read latency 0).
interface sopc_pio_bidir_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sopc_pio_sync_edge.sv
// Multi-flop input synchroniser followed by an edge-history flop and the
// compile-time selected edge detector.
module sopc_pio_sync_edge
  import sopc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= din_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_o = sync_o ^ prev_q;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_o = sync_o & ~prev_q;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_o = ~sync_o & prev_q;
    end
  end

endmodule

// File: rtl/sopc_pio_bidir.sv
// WIDTH-bit Avalon-MM general-purpose I/O slave with per-bit direction,
// edge capture with masked level interrupt, atomic set/clear and open-drain mode.
module sopc_pio_bidir
  import sopc_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = EDGE_ANY,
  parameter int               OPEN_DRAIN  = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sopc_pio_bidir_if.slave      avs,
  output logic                 irq,
  input  logic [WIDTH-1:0]     pio_in,
  output logic [WIDTH-1:0]     pio_out,
  output logic [WIDTH-1:0]     pio_oe
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q,  cap_d;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_w;
  logic [31:0]      rd32;
  logic             wr_en;

  sopc_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .din_i   (pio_in),
    .sync_o  (sync_in),
    .edge_o  (edge_pulse)
  );

  assign wr_en = avs.chipselect & ~avs.write_n;
  assign wd    = avs.writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_wd_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^avs.writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    data_d  = data_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    cap_clr = '0;
    if (wr_en) begin
      case (avs.address)
        ADDR_DATA:    data_d  = wd;
        ADDR_DIR:     dir_d   = wd;
        ADDR_IRQMASK: mask_d  = wd;
        ADDR_EDGECAP: cap_clr = wd;
        ADDR_OUTSET:  data_d  = data_q | wd;
        ADDR_OUTCLR:  data_d  = data_q & ~wd;
        default:      ;
      endcase
    end
    // Set is applied after clear so an edge coinciding with a clear is kept.
    cap_d = (cap_q & ~cap_clr) | edge_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    rd_w = '0;
    case (avs.address)
      ADDR_DATA:    rd_w = sync_in;
      ADDR_DIR:     rd_w = dir_q;
      ADDR_IRQMASK: rd_w = mask_q;
      ADDR_EDGECAP: rd_w = cap_q;
      default:      rd_w = '0;
    endcase
    rd32 = 32'(rd_w);
  end

  assign avs.readdata = pio_zext(rd32, WIDTH);
  assign irq          = |(cap_q & mask_q);

  // Open-drain: a data 1 turns the driver off and the external pull-up wins.
  generate
    if (OPEN_DRAIN != 0) begin : g_od
      assign pio_out = '0;
      assign pio_oe  = dir_q & ~data_q;
    end else begin : g_pp
      assign pio_out = data_q;
      assign pio_oe  = dir_q;
    end
  endgenerate

endmodule

// File: tb/tb_sopc_pio_bidir.sv
// Directed scoreboard bench for sopc_pio_bidir: a push-pull rising-edge
// instance and an open-drain instance share clock and reset.
module tb_sopc_pio_bidir;
  import sopc_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] gp_pin = 8'h00;
  logic [7:0] od_pin = 8'h00;
  logic [7:0] gp_out, gp_oe, od_out, od_oe;
  logic       gp_irq, od_irq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sopc_pio_bidir_if if_gp();
  sopc_pio_bidir_if if_od();

  sopc_pio_bidir #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .RESET_DIR(8'hF0),
    .EDGE_TYPE(EDGE_RISE), .OPEN_DRAIN(0), .SYNC_STAGES(2)
  ) u_gp (
    .clk(clk), .reset_n(reset_n), .avs(if_gp), .irq(gp_irq),
    .pio_in(gp_pin), .pio_out(gp_out), .pio_oe(gp_oe)
  );

  sopc_pio_bidir #(
    .WIDTH(8), .RESET_VALUE(8'h02), .RESET_DIR(8'h00),
    .EDGE_TYPE(EDGE_ANY), .OPEN_DRAIN(1), .SYNC_STAGES(2)
  ) u_od (
    .clk(clk), .reset_n(reset_n), .avs(if_od), .irq(od_irq),
    .pio_in(od_pin), .pio_out(od_out), .pio_oe(od_oe)
  );

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=0x%0h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(tag, exp);
    check_obs(obs);
  endtask

  task automatic rd(input bit od, input logic [2:0] a, input logic [31:0] exp, input string tag);
    push_exp(tag, exp);
    if (od) if_od.address = a;
    else    if_gp.address = a;
    #1;
    check_obs(od ? if_od.readdata : if_gp.readdata);
  endtask

  task automatic wr(input bit od, input logic [2:0] a, input logic [31:0] d,
                    input bit cs = 1'b1, input bit wn = 1'b0);
    if (od) begin
      if_od.address = a; if_od.writedata = d; if_od.chipselect = cs; if_od.write_n = wn;
    end else begin
      if_gp.address = a; if_gp.writedata = d; if_gp.chipselect = cs; if_gp.write_n = wn;
    end
    @(posedge clk);
    #1;
    if_od.chipselect = 1'b0; if_od.write_n = 1'b1;
    if_gp.chipselect = 1'b0; if_gp.write_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_gp.address = 3'd0; if_gp.chipselect = 1'b0; if_gp.write_n = 1'b1; if_gp.writedata = '0;
    if_od.address = 3'd0; if_od.chipselect = 1'b0; if_od.write_n = 1'b1; if_od.writedata = '0;

    // Reset defaults while reset_n is held low.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_gp_out", 32'(gp_out), 32'hA5);
    chk("rst_gp_oe",  32'(gp_oe),  32'hF0);
    chk("rst_gp_irq", 32'(gp_irq), 32'h0);
    rd(0, ADDR_IRQMASK, 32'h0,  "rst_irqmask");
    rd(0, ADDR_EDGECAP, 32'h0,  "rst_edgecap");
    rd(0, ADDR_DIR,     32'hF0, "rst_dir");
    chk("rst_od_oe",  32'(od_oe),  32'h00);
    chk("rst_od_out", 32'(od_out), 32'h00);
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Data load, atomic set and clear, ignored writes.
    wr(0, ADDR_DATA,   32'h0F);
    chk("data_load", 32'(gp_out), 32'h0F);
    wr(0, ADDR_OUTSET, 32'h30);
    chk("outset", 32'(gp_out), 32'h3F);
    wr(0, ADDR_OUTCLR, 32'h01);
    chk("outclr", 32'(gp_out), 32'h3E);
    wr(0, ADDR_DATA, 32'hFF, 1'b0, 1'b0);
    chk("cs_low_ignored", 32'(gp_out), 32'h3E);
    wr(0, ADDR_DATA, 32'hFF, 1'b1, 1'b1);
    chk("wn_high_ignored", 32'(gp_out), 32'h3E);
    wr(0, 3'd6, 32'hFF);
    chk("addr6_ignored", 32'(gp_out), 32'h3E);
    rd(0, ADDR_OUTSET, 32'h0, "rd_outset");
    rd(0, ADDR_OUTCLR, 32'h0, "rd_outclr");
    rd(0, 3'd6,        32'h0, "rd_addr6");
    rd(0, 3'd7,        32'h0, "rd_addr7");
    wr(0, ADDR_DIR, 32'hFFFF_FF5A);
    rd(0, ADDR_DIR, 32'h5A, "dir_rw_upper_zero");
    chk("dir_oe", 32'(gp_oe), 32'h5A);

    // Input latency and rising-edge capture with masked interrupt.
    wr(0, ADDR_IRQMASK, 32'h01);
    rd(0, ADDR_IRQMASK, 32'h01, "irqmask_rw");
    cycles(1);
    gp_pin = 8'h81;
    rd(0, ADDR_DATA, 32'h00, "sync_n0");
    cycles(1);
    rd(0, ADDR_DATA, 32'h00, "sync_n1");
    cycles(1);
    rd(0, ADDR_DATA,    32'h81, "sync_n2");
    rd(0, ADDR_EDGECAP, 32'h00, "cap_n2");
    cycles(1);
    rd(0, ADDR_EDGECAP, 32'h81, "cap_n3");
    chk("irq_set", 32'(gp_irq), 32'h1);
    wr(0, ADDR_EDGECAP, 32'h01);
    chk("irq_clr_next", 32'(gp_irq), 32'h0);
    rd(0, ADDR_EDGECAP, 32'h80, "cap_partial_clr");
    wr(0, ADDR_EDGECAP, 32'h80);
    rd(0, ADDR_EDGECAP, 32'h00, "cap_all_clr");
    gp_pin = 8'h00;
    cycles(4);
    rd(0, ADDR_EDGECAP, 32'h00, "fall_ignored");
    chk("fall_irq", 32'(gp_irq), 32'h0);

    // Edge and clear landing in the same cycle: the set must win.
    gp_pin = 8'h01;
    cycles(4);
    rd(0, ADDR_EDGECAP, 32'h01, "pre_collision_cap");
    gp_pin = 8'h00;
    cycles(4);
    gp_pin = 8'h01;
    cycles(2);
    wr(0, ADDR_EDGECAP, 32'h01);
    rd(0, ADDR_EDGECAP, 32'h01, "collision_cap");
    chk("collision_irq", 32'(gp_irq), 32'h1);
    wr(0, ADDR_EDGECAP, 32'h01);
    rd(0, ADDR_EDGECAP, 32'h00, "post_collision_clr");
    chk("post_collision_irq", 32'(gp_irq), 32'h0);

    // Open-drain drive.
    wr(1, ADDR_DIR,  32'h01);
    wr(1, ADDR_DATA, 32'h00);
    chk("od_drive_oe",  32'(od_oe),  32'h01);
    chk("od_drive_out", 32'(od_out), 32'h00);
    wr(1, ADDR_DATA, 32'h01);
    chk("od_release_oe", 32'(od_oe), 32'h00);
    wr(1, ADDR_DATA, 32'h00);
    chk("od_redrive_oe", 32'(od_oe), 32'h01);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_od_oe",  32'(od_oe),  32'h00);
    chk("arst_od_out", 32'(od_out), 32'h00);
    chk("arst_gp_out", 32'(gp_out), 32'hA5);
    chk("arst_gp_oe",  32'(gp_oe),  32'hF0);
    chk("arst_gp_irq", 32'(gp_irq), 32'h0);
    rd(1, ADDR_DIR,     32'h00, "arst_od_dir");
    rd(0, ADDR_EDGECAP, 32'h00, "arst_gp_cap");
    rd(0, ADDR_IRQMASK, 32'h00, "arst_gp_mask");
    rd(0, ADDR_DATA,    32'h00, "arst_gp_sync");
    cycles(2);
    reset_n = 1'b1;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
